spi_receiver: RTL and testbench
===============================

SPI_RECEIVER -- requirements
Module: spi_receiver

Interface
REQ-001 SHALL have parameter DATA_W, default 24, bits per frame; legal range 1-63.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops per SPI input; legal range 2-3.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous active-low reset.
REQ-005 SHALL have port spi_cs_l  input  1  chip select, active low, asynchronous to clk.
REQ-006 SHALL have port spi_sclk  input  1  serial clock, idle low, data sampled on its rising edge.
REQ-007 SHALL have port spi_data  input  1  serial data, MSB first.
REQ-008 SHALL have port rx_data  output  DATA_W  received word at head of buffer.
REQ-009 SHALL have port rx_valid  output  1  rx_data holds an unread word.
REQ-010 SHALL have port rx_ready  input  1  consumer accepts word when rx_valid and rx_ready are both high.
REQ-011 SHALL have port counter  output  6  bits received in current frame.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on short frame.
REQ-013 SHALL have port overrun  output  1  one-cycle pulse when a completed word is dropped.

Function
REQ-014 SHALL pass spi_cs_l, spi_sclk, spi_data through SYNC_STAGES-flop synchronizers; all decisions use synchronized values.
REQ-015 SHALL detect an sclk rising edge as synchronized sclk high while its previous-cycle value was low.
REQ-016 SHALL implement states IDLE, SHIFT, WAIT_CS.
REQ-017 IDLE: synchronized cs_l low -> SHIFT with counter=0, shift register cleared.
REQ-018 SHIFT: each detected edge shifts synchronized data into LSB of shift register (MSB first overall), counter+1.
REQ-019 SHIFT: edge bringing counter to DATA_W -> push assembled word to buffer, counter=0, next state WAIT_CS.
REQ-020 SHIFT: cs_l high with counter!=0 -> discard partial word, frame_err pulse next cycle, -> IDLE; with counter==0 -> IDLE silently.
REQ-021 WAIT_CS: ignore sclk edges; cs_l high -> IDLE; cs_l low plus edge -> SHIFT treating that edge as bit 1 of next frame (back-to-back frames).
REQ-022 SHALL assert rx_valid the clk cycle after the push cycle; rx_data stable while rx_valid high and rx_ready low.
REQ-023 Push into full buffer SHALL drop the new word, keep stored words, pulse overrun next cycle.
REQ-024 Push and pop in same cycle on full buffer SHALL accept the push (no overrun).
REQ-025 Correct reception requires sclk high and low phases each >= SYNC_STAGES+1 clk cycles; faster sclk is unsupported.
REQ-026 counter SHALL equal bits shifted so far; 0 in IDLE and WAIT_CS.

Reset
REQ-027 reset low at a clk edge SHALL force IDLE, counter=0, rx_valid=0, rx_data=0, frame_err=0, overrun=0, buffer empty, synchronizers to idle (cs_l=1, sclk=0, data=0).
REQ-028 reset mid-frame SHALL discard the partial word without frame_err; after release, reception restarts only on a cs_l low observed in IDLE.

Configuration
REQ-029 Macro SPI_RX_FIFO_EN defined: buffer is a 4-entry FIFO, rx_data shows oldest entry, full = 4 entries.
REQ-030 Macro SPI_RX_FIFO_EN undefined: buffer is a single holding register, full = rx_valid high.

Verification
REQ-031 Reset low 3 cycles then release -> all outputs zero, state IDLE, counter 0.
REQ-032 One frame 24'hA5C3F0, rx_ready=1 -> single rx_valid cycle with rx_data 24'hA5C3F0, frame_err=0.
REQ-033 cs_l rises after 10 bits -> frame_err one-cycle pulse, no rx_valid, counter back to 0.
REQ-034 rx_ready=0, frames 24'h000001..24'h000005 -> without macro overrun pulses 4 times and rx_data=24'h000001; with macro overrun pulses once and pops yield 1,2,3,4.
REQ-035 Back-to-back frames 24'hFFFFFF, 24'h000000 without cs_l release -> two words in order, no frame_err.
REQ-036 reset asserted after 12 bits, then full frame 24'h123456 -> only 24'h123456 delivered, no frame_err.

Source files
------------

// File: rtl/spi_receiver.sv
// SPI slave receiver: synchronizes CS/SCLK/DATA into clk, assembles MSB-first words, buffers them.
// Optional macro SPI_RX_FIFO_EN selects a 4-entry FIFO instead of a single holding register.
module spi_receiver #(
    parameter int unsigned DATA_W      = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_cs_l,
    input  logic              spi_sclk,
    input  logic              spi_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [5:0]        counter,
    output logic              frame_err,
    output logic              overrun
);

    localparam int unsigned CNT_W      = 6;
    localparam logic [CNT_W-1:0] FRAME_BITS = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WAIT_CS = 2'd2
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  cs_sync;
    logic [SYNC_STAGES-1:0]  sclk_sync;
    logic [SYNC_STAGES-1:0]  data_sync;
    logic                    sclk_prev;
    logic                    cs_s;
    logic                    sclk_s;
    logic                    data_s;
    logic                    sclk_rise;
    logic [DATA_W-1:0]       shreg;
    logic [DATA_W-1:0]       shifted;
    logic [DATA_W-1:0]       first_word;
    logic [DATA_W-1:0]       push_word;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    push;
    logic                    pop;

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign data_s    = data_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign pop       = rx_valid & rx_ready;

    // Input synchronizers; reset parks them at the bus idle levels.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            data_sync <= '0;
            sclk_prev <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_l};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], spi_data};
            sclk_prev <= sclk_s;
        end
    end

    // Word completion: a frame edge in SHIFT, or the first edge of a new frame when DATA_W is 1.
    always_comb begin
        cnt_inc    = counter + CNT_W'(1);
        shifted    = DATA_W'({shreg, data_s});
        first_word = DATA_W'(data_s);
        push       = 1'b0;
        push_word  = shifted;
        case (state)
            SHIFT: begin
                push = ~cs_s & sclk_rise & (cnt_inc == FRAME_BITS);
            end
            WAIT_CS: begin
                push      = ~cs_s & sclk_rise & (FRAME_BITS == CNT_W'(1));
                push_word = first_word;
            end
            default: begin
                push = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            counter   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!cs_s) begin
                        state   <= SHIFT;
                        counter <= '0;
                        shreg   <= '0;
                    end
                end
                SHIFT: begin
                    if (cs_s) begin
                        frame_err <= (counter != '0);
                        counter   <= '0;
                        state     <= IDLE;
                    end else if (sclk_rise) begin
                        if (push) begin
                            counter <= '0;
                            state   <= WAIT_CS;
                        end else begin
                            counter <= cnt_inc;
                            shreg   <= shifted;
                        end
                    end
                end
                WAIT_CS: begin
                    // An edge while CS stays low starts the next back-to-back frame.
                    if (cs_s) begin
                        state <= IDLE;
                    end else if (sclk_rise && !push) begin
                        state   <= SHIFT;
                        counter <= CNT_W'(1);
                        shreg   <= first_word;
                    end
                end
                default: begin
                    state   <= IDLE;
                    counter <= '0;
                end
            endcase
        end
    end

`ifdef SPI_RX_FIFO_EN
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;
    localparam int unsigned CNT_F = 3;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_F-1:0]  count;
    logic [PTR_W-1:0]  wr_n;
    logic [PTR_W-1:0]  rd_n;
    logic [CNT_F-1:0]  cnt_n;
    logic              full;
    logic              accept;
    logic [DATA_W-1:0] head_n;

    // Next head is the pushed word only when it lands in the slot that becomes oldest.
    always_comb begin
        full   = (count == CNT_F'(DEPTH));
        accept = push & (~full | pop);
        wr_n   = PTR_W'(wr_ptr + PTR_W'(accept));
        rd_n   = PTR_W'(rd_ptr + PTR_W'(pop));
        cnt_n  = CNT_F'(count + CNT_F'(accept) - CNT_F'(pop));
        head_n = (accept && (wr_ptr == rd_n)) ? push_word : mem[rd_n];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= push_word;
            end
            wr_ptr   <= wr_n;
            rd_ptr   <= rd_n;
            count    <= cnt_n;
            rx_data  <= head_n;
            rx_valid <= (cnt_n != '0);
            overrun  <= push & ~accept;
        end
    end
`else
    // Single holding register; a pop in the same cycle frees it for the incoming word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (push) begin
                if (!rx_valid || pop) begin
                    rx_data  <= push_word;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (pop) begin
                rx_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_receiver.sv
// Directed bench for spi_receiver: reset, single frame, short frame, overrun, back-to-back, mid-frame reset.
module tb_spi_receiver;

    localparam int unsigned DATA_W = 24;
`ifdef SPI_RX_FIFO_EN
    localparam int EXP_OV   = 1;
    localparam int EXP_POPS = 4;
`else
    localparam int EXP_OV   = 4;
    localparam int EXP_POPS = 1;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              spi_cs_l = 1'b1;
    logic              spi_sclk = 1'b0;
    logic              spi_data = 1'b0;
    logic              rx_ready = 1'b1;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic [5:0]        counter;
    logic              frame_err;
    logic              overrun;

    int vectors     = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] got[$];
    int fe_total   = 0;
    int ov_total   = 0;
    int vcyc_total = 0;
    int w0, f0, o0, v0;

    spi_receiver #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .spi_cs_l  (spi_cs_l),
        .spi_sclk  (spi_sclk),
        .spi_data  (spi_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .counter   (counter),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Observe outputs on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        if (rx_valid) vcyc_total++;
        if (rx_valid && rx_ready) got.push_back(rx_data);
        if (frame_err) fe_total++;
        if (overrun) ov_total++;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1);
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [63:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi_data = val[i];
            wait_clks(5);
            spi_sclk = 1'b1;
            wait_clks(5);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [63:0] val);
        spi_cs_l = 1'b0;
        wait_clks(5);
        send_bits(val, DATA_W);
        wait_clks(5);
        spi_cs_l = 1'b1;
        wait_clks(10);
    endtask

    task automatic mark();
        w0 = got.size();
        f0 = fe_total;
        o0 = ov_total;
        v0 = vcyc_total;
    endtask

    function automatic logic [63:0] word_at(input int idx);
        if (idx < got.size()) return 64'(got[idx]);
        return '1;
    endfunction

    initial begin
        // Reset
        wait_clks(3);
        reset = 1'b1;
        wait_clks(2);
        check("rst_rx_valid", 64'(rx_valid), 64'd0);
        check("rst_rx_data", 64'(rx_data), 64'd0);
        check("rst_counter", 64'(counter), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);

        // Single frame
        mark();
        send_frame(64'hA5C3F0);
        check("single_words", 64'(got.size() - w0), 64'd1);
        check("single_data", word_at(w0), 64'hA5C3F0);
        check("single_valid_cycles", 64'(vcyc_total - v0), 64'd1);
        check("single_frame_err", 64'(fe_total - f0), 64'd0);
        check("single_counter", 64'(counter), 64'd0);

        // Short frame of 10 bits
        mark();
        spi_cs_l = 1'b0;
        wait_clks(5);
        send_bits(64'h2AB, 10);
        wait_clks(2);
        check("short_counter_mid", 64'(counter), 64'd10);
        spi_cs_l = 1'b1;
        wait_clks(10);
        check("short_frame_err", 64'(fe_total - f0), 64'd1);
        check("short_no_valid", 64'(vcyc_total - v0), 64'd0);
        check("short_counter_end", 64'(counter), 64'd0);

        // Overrun with consumer stalled
        mark();
        rx_ready = 1'b0;
        for (int k = 1; k <= 5; k++) send_frame(64'(k));
        check("ovr_pulses", 64'(ov_total - o0), 64'(EXP_OV));
        check("ovr_valid", 64'(rx_valid), 64'd1);
        check("ovr_head", 64'(rx_data), 64'd1);
        rx_ready = 1'b1;
        for (int i = 0; i < 20 && rx_valid; i++) wait_clks(1);
        check("ovr_drained", 64'(rx_valid), 64'd0);
        check("ovr_pops", 64'(got.size() - w0), 64'(EXP_POPS));
        for (int i = 0; i < EXP_POPS; i++) check("ovr_pop_data", word_at(w0 + i), 64'(i + 1));

        // Back-to-back frames with CS held low
        mark();
        spi_cs_l = 1'b0;
        wait_clks(5);
        send_bits(64'hFFFFFF, DATA_W);
        send_bits(64'h000000, DATA_W);
        wait_clks(5);
        spi_cs_l = 1'b1;
        wait_clks(10);
        check("b2b_words", 64'(got.size() - w0), 64'd2);
        check("b2b_first", word_at(w0), 64'hFFFFFF);
        check("b2b_second", word_at(w0 + 1), 64'h000000);
        check("b2b_frame_err", 64'(fe_total - f0), 64'd0);

        // Reset in the middle of a frame
        mark();
        spi_cs_l = 1'b0;
        wait_clks(5);
        send_bits(64'hABC, 12);
        wait_clks(2);
        check("midrst_counter_pre", 64'(counter), 64'd12);
        reset = 1'b0;
        wait_clks(3);
        spi_cs_l = 1'b1;
        reset = 1'b1;
        wait_clks(10);
        check("midrst_counter_post", 64'(counter), 64'd0);
        send_frame(64'h123456);
        check("midrst_words", 64'(got.size() - w0), 64'd1);
        check("midrst_data", word_at(w0), 64'h123456);
        check("midrst_frame_err", 64'(fe_total - f0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
